// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared types and limits for the GEMM K-tile sequencer: Info beat tag,
// counter widths sized from the tile limits, and the sequencer state enum.
package gemm_tile_sequencer_pkg;

  localparam int MAX_TILE_SIZE_M = 512;
  localparam int MAX_TILES       = 1024;
  localparam int MIN_TILE_CYCLES = 8;

  localparam int TILE_M_W = $clog2(MAX_TILE_SIZE_M + 1);
  localparam int TILE_W   = $clog2(MAX_TILES + 1);

  typedef logic [TILE_M_W-1:0] TileMCnt;
  typedef logic [TILE_W-1:0]   TileCnt;

  typedef struct packed {
    logic valid;
    logic first_tile_k;
    logic last_tile_k;
    logic new_tile_k;
  } Info;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP
  } SeqState;

endpackage

// File: rtl/gemm_tile_sequencer_tile_counter.sv
// Wrapping up-counter with synchronous clear, programmable terminal value
// and a registered wrap flag (high the cycle after the terminal count is consumed).
module tile_counter #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_at_last,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         r_wrap;

  assign o_at_last = (r_cnt == i_last);
  assign o_cnt     = r_cnt;
  assign o_wrap    = r_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= i_en & o_at_last;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= o_at_last ? '0 : r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Gates operand beats toward the MXU and tags each with its K-tile position,
// padding short K-tiles so the accumulator RMW loop keeps up.
// Optional stall counter output enabled by `define GEMM_TILE_SEQ_STALL_CNT_EN.
module gemm_tile_sequencer
  import gemm_tile_sequencer_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    cfg_valid,
  output logic    cfg_ready,
  input  TileMCnt cfg_tile_size_m,
  input  TileCnt  cfg_num_tiles_k,
  input  TileCnt  cfg_num_tiles_n,
  output logic    cfg_err,
  input  logic    in_valid,
  output logic    in_ready,
  output Info     qinfo,
  output logic    busy,
  output logic    done
`ifdef GEMM_TILE_SEQ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int ELAP_W = $clog2(MIN_TILE_CYCLES + 1);
  localparam logic [ELAP_W-1:0] ELAP_MAX  = ELAP_W'(MIN_TILE_CYCLES);
  localparam logic [ELAP_W-1:0] ELAP_EXIT = ELAP_W'(MIN_TILE_CYCLES - 1);

  SeqState r_state, w_next;
  TileMCnt r_m;
  TileCnt  r_k, r_n;
  TileMCnt w_row;
  TileCnt  w_kc, w_nc;
  logic    w_row_last, w_k_last, w_n_last;
  logic    w_row_wrap, w_k_wrap, w_n_wrap;
  logic    w_unused;
  logic [ELAP_W-1:0] r_elapsed, w_elapsed_now;
  Info     r_qinfo_p1;
  logic    r_cfg_err;
  logic    w_cfg_take, w_cfg_bad, w_start, w_beat, w_job_last, w_tile_end;

  assign w_cfg_take = cfg_valid & (r_state == IDLE);
  assign w_cfg_bad  = (cfg_tile_size_m == '0) | (cfg_tile_size_m > TileMCnt'(MAX_TILE_SIZE_M)) |
                      (cfg_num_tiles_k == '0) | (cfg_num_tiles_k > TileCnt'(MAX_TILES)) |
                      (cfg_num_tiles_n == '0) | (cfg_num_tiles_n > TileCnt'(MAX_TILES));
  assign w_start    = w_cfg_take & ~w_cfg_bad;
  assign w_beat     = (r_state == RUN) & in_valid;
  assign w_job_last = w_beat & w_row_last & w_k_last & w_n_last;
  assign w_tile_end = w_beat & w_row_last & ~w_job_last;
  // A tile's first beat counts as zero elapsed cycles (matters for M == 1).
  assign w_elapsed_now = (w_row == '0) ? '0 : r_elapsed;

  tile_counter #(.W(TILE_M_W)) u_row (
    .i_clk(clk), .i_rst(resetn), .i_clear(w_start), .i_en(w_beat),
    .i_last(r_m - TileMCnt'(1)), .o_cnt(w_row), .o_at_last(w_row_last), .o_wrap(w_row_wrap)
  );

  tile_counter #(.W(TILE_W)) u_k (
    .i_clk(clk), .i_rst(resetn), .i_clear(w_start), .i_en(w_beat & w_row_last),
    .i_last(r_k - TileCnt'(1)), .o_cnt(w_kc), .o_at_last(w_k_last), .o_wrap(w_k_wrap)
  );

  // The n counter only wraps on the job's final beat, so its wrap flag is done.
  tile_counter #(.W(TILE_W)) u_n (
    .i_clk(clk), .i_rst(resetn), .i_clear(w_start), .i_en(w_beat & w_row_last & w_k_last),
    .i_last(r_n - TileCnt'(1)), .o_cnt(w_nc), .o_at_last(w_n_last), .o_wrap(w_n_wrap)
  );

  assign w_unused = w_row_wrap ^ w_k_wrap ^ (^w_nc);

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_m <= cfg_tile_size_m;
      r_k <= cfg_num_tiles_k;
      r_n <= cfg_num_tiles_n;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (w_start) w_next = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (w_job_last) begin
          w_next = IDLE;
        end else if (w_tile_end && (w_elapsed_now < ELAP_EXIT)) begin
          w_next = GAP;
        end
      end
      GAP: begin
        if (r_elapsed >= ELAP_EXIT) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  // p1: registered beat tag, reject pulse and elapsed-since-tile-start count
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_qinfo_p1 <= '0;
      r_cfg_err  <= 1'b0;
      r_elapsed  <= '0;
    end else begin
      r_cfg_err <= w_cfg_take & w_cfg_bad;
      if (w_beat) begin
        r_qinfo_p1 <= '{valid: 1'b1, first_tile_k: (w_kc == '0),
                        last_tile_k: w_k_last, new_tile_k: (w_row == '0)};
      end else begin
        r_qinfo_p1 <= '0;
      end
      if (w_beat && (w_row == '0)) begin
        r_elapsed <= ELAP_W'(1);
      end else if (r_elapsed != ELAP_MAX) begin
        r_elapsed <= r_elapsed + 1'b1;
      end
    end
  end

  assign qinfo   = r_qinfo_p1;
  assign cfg_err = r_cfg_err;
  assign done    = w_n_wrap;

`ifdef GEMM_TILE_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if ((((r_state == RUN) && !in_valid) || (r_state == GAP)) && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed bench for gemm_tile_sequencer: job table plus reset and back-to-back sequences.
module tb_gemm_tile_sequencer;

  logic        clk = 1'b0;
  logic        resetn, cfg_valid, in_valid;
  logic [9:0]  cfg_m;
  logic [10:0] cfg_k, cfg_n;
  logic        cfg_ready, cfg_err, in_ready, busy, done;
  logic [3:0]  qinfo;
`ifdef GEMM_TILE_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gemm_tile_sequencer dut (
    .clk(clk), .resetn(resetn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tile_size_m(cfg_m), .cfg_num_tiles_k(cfg_k), .cfg_num_tiles_n(cfg_n),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .qinfo(qinfo),
    .busy(busy), .done(done)
`ifdef GEMM_TILE_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    int m; int k; int n; bit tog; bit err;
    int beats; int first; int last; int newt; int cycles; int low;
  } job_t;

  job_t     jobs[14];
  logic [3:0] beat_q[2048];
  int       beat_it[2048];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input job_t j, input int idx);
    int it, nb, nf, nl, nn, low, done_it, done_v, busy_d, rdy_d, spur, nerr;
    nb = 0; nf = 0; nl = 0; nn = 0; low = 0; done_it = -1; done_v = 0;
    busy_d = 1; rdy_d = 0; spur = 0; nerr = 0; it = 0;
    cfg_m = j.m[9:0];
    cfg_k = j.k[10:0];
    cfg_n = j.n[10:0];
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    if (j.err) begin
      chk($sformatf("job%0d cfg_err", idx), cfg_err, 1);
      chk($sformatf("job%0d busy_on_err", idx), busy, 0);
      chk($sformatf("job%0d cfg_ready_on_err", idx), cfg_ready, 1);
      in_valid = 1'b1;
      for (int c = 0; c < 4; c++) begin
        cyc();
        if (qinfo[3]) nb++;
        if (cfg_err) nerr++;
        if (busy) spur++;
      end
      in_valid = 1'b0;
      chk($sformatf("job%0d err_beats", idx), nb, 0);
      chk($sformatf("job%0d err_pulse_len", idx), nerr, 0);
      chk($sformatf("job%0d err_busy", idx), spur, 0);
    end else begin
      chk($sformatf("job%0d busy_start", idx), busy, 1);
      chk($sformatf("job%0d cfg_err_ok", idx), cfg_err, 0);
      while (done_it < 0 && it < j.cycles + 64) begin
        in_valid = j.tog ? (it % 2 == 0) : 1'b1;
        cyc();
        it++;
        if (qinfo[3]) begin
          beat_q[nb % 2048]  = qinfo;
          beat_it[nb % 2048] = it;
          nb++;
          if (qinfo[2]) nf++;
          if (qinfo[1]) nl++;
          if (qinfo[0]) nn++;
        end else if (qinfo[2:0] != 3'b000) begin
          spur++;
        end
        if (done) begin
          done_it = it;
          done_v  = qinfo[3];
          busy_d  = busy;
          rdy_d   = cfg_ready;
        end else if (!in_ready) begin
          low++;
        end
      end
      in_valid = 1'b0;
      chk($sformatf("job%0d done_cycle", idx), done_it, j.cycles);
      chk($sformatf("job%0d beats", idx), nb, j.beats);
      chk($sformatf("job%0d first_cnt", idx), nf, j.first);
      chk($sformatf("job%0d last_cnt", idx), nl, j.last);
      chk($sformatf("job%0d new_cnt", idx), nn, j.newt);
      chk($sformatf("job%0d ready_low", idx), low, j.low);
      chk($sformatf("job%0d spurious_fields", idx), spur, 0);
      chk($sformatf("job%0d done_with_beat", idx), done_v, 1);
      chk($sformatf("job%0d busy_at_done", idx), busy_d, 0);
      chk($sformatf("job%0d ready_at_done", idx), rdy_d, 1);
      cyc();
      chk($sformatf("job%0d done_pulse", idx), done, 0);
      chk($sformatf("job%0d qinfo_idle", idx), qinfo, 0);
`ifdef GEMM_TILE_SEQ_STALL_CNT_EN
      if (j.tog) chk($sformatf("job%0d stall_cnt", idx), stall_cnt, 7);
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    logic [3:0] exp_q;
    jobs[0]  = '{4,    3,    1,    1'b0, 1'b0, 12,   4,   4,   3,    20,   8};
    jobs[1]  = '{2,    2,    2,    1'b0, 1'b0, 8,    4,   4,   4,    26,   18};
    jobs[2]  = '{8,    1,    1,    1'b1, 1'b0, 8,    8,   8,   1,    15,   0};
    jobs[3]  = '{1,    1,    3,    1'b0, 1'b0, 3,    3,   3,   3,    17,   14};
    jobs[4]  = '{10,   2,    1,    1'b0, 1'b0, 20,   10,  10,  2,    20,   0};
    jobs[5]  = '{8,    2,    1,    1'b0, 1'b0, 16,   8,   8,   2,    16,   0};
    jobs[6]  = '{512,  1,    1,    1'b0, 1'b0, 512,  512, 512, 1,    512,  0};
    jobs[7]  = '{1,    1024, 1,    1'b0, 1'b0, 1024, 1,   1,   1024, 8185, 7161};
    jobs[8]  = '{513,  1,    1,    1'b0, 1'b1, 0,    0,   0,   0,    0,    0};
    jobs[9]  = '{4,    0,    1,    1'b0, 1'b1, 0,    0,   0,   0,    0,    0};
    jobs[10] = '{0,    3,    1,    1'b0, 1'b1, 0,    0,   0,   0,    0,    0};
    jobs[11] = '{4,    3,    0,    1'b0, 1'b1, 0,    0,   0,   0,    0,    0};
    jobs[12] = '{4,    1025, 1,    1'b0, 1'b1, 0,    0,   0,   0,    0,    0};
    jobs[13] = '{4,    1,    1025, 1'b0, 1'b1, 0,    0,   0,   0,    0,    0};

    resetn = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0;
    cyc(); cyc();
    chk("rst cfg_ready", cfg_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst qinfo", qinfo, 0);
    chk("rst done", done, 0);
    chk("rst cfg_err", cfg_err, 0);
`ifdef GEMM_TILE_SEQ_STALL_CNT_EN
    chk("rst stall_cnt", stall_cnt, 0);
`endif
    resetn = 1'b0;
    cyc();

    for (int i = 0; i < 14; i++) begin
      run_job(jobs[i], i);
      if (i == 0) begin
        for (int b = 0; b < 12; b++) begin
          exp_q = {1'b1, (b < 4), (b >= 8), (b % 4 == 0)};
          chk($sformatf("job0 beat%0d flags", b), beat_q[b], exp_q);
        end
      end
      if (i == 1) begin
        chk("job1 first_beat_cycle", beat_it[0], 1);
        for (int t = 1; t < 4; t++)
          chk($sformatf("job1 ktile%0d spacing", t), beat_it[2*t] - beat_it[2*t-2], 8);
      end
      cyc();
    end

    // Reset in the middle of a K-tile
    cfg_m = 10'd16; cfg_k = 11'd4; cfg_n = 11'd1;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    in_valid = 1'b1;
    nb = 0;
    for (int c = 0; c < 40 && nb < 20; c++) begin
      cyc();
      if (qinfo[3]) nb++;
    end
    chk("midrst beats_before", nb, 20);
    resetn = 1'b1;
    #1;
    chk("midrst cfg_ready", cfg_ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst in_ready", in_ready, 0);
    chk("midrst qinfo", qinfo, 0);
    chk("midrst done", done, 0);
    in_valid = 1'b0;
    cyc();
    resetn = 1'b0;
    cyc();
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    in_valid = 1'b1;
    cyc();
    chk("midrst restart beat0", qinfo, 4'b1101);
    cyc();
    chk("midrst restart beat1", qinfo, 4'b1100);
    in_valid = 1'b0;
    resetn = 1'b1;
    cyc();
    resetn = 1'b0;
    cyc();

    // Back-to-back jobs with cfg_valid held high
    cfg_m = 10'd2; cfg_k = 11'd1; cfg_n = 11'd1;
    cfg_valid = 1'b1;
    in_valid = 1'b1;
    cyc();
    chk("b2b busy1", busy, 1);
    cyc();
    chk("b2b job1 beat0", qinfo, 4'b1111);
    cyc();
    chk("b2b job1 beat1", qinfo, 4'b1110);
    chk("b2b job1 done", done, 1);
    chk("b2b ready_at_done", cfg_ready, 1);
    cyc();
    chk("b2b busy2", busy, 1);
    chk("b2b no_overlap", qinfo, 0);
    chk("b2b done_low", done, 0);
    cyc();
    chk("b2b job2 beat0", qinfo, 4'b1111);
    cyc();
    chk("b2b job2 beat1", qinfo, 4'b1110);
    chk("b2b job2 done", done, 1);
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk("b2b idle_after", busy, 0);
    chk("b2b qinfo_after", qinfo, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
